// File: rtl/mp3_key_ctrl.sv
// Front-panel key front end: per-key synchronise/debounce/press detect, track and
// volume command pulses, volume level, pause state and auto-advance on end of track.
module mp3_key_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 2_000_000,
  parameter logic [3:0]  VOL_RESET    = 4'd8,
  parameter logic [3:0]  VOL_MAX      = 4'd15,
  parameter bit          AUTO_NEXT    = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_BTN,
  input  logic       i_key_next,
  input  logic       i_key_pre,
  input  logic       i_key_vplus,
  input  logic       i_key_vdec,
  input  logic       i_key_pause,
  input  logic       i_finish_song,
  output logic       o_next,
  output logic       o_pre,
  output logic       o_vol_plus,
  output logic       o_vol_dec,
  output logic       o_pause,
  output logic [3:0] o_vol_level
);

  localparam int unsigned NKEY = 5;
  localparam int unsigned CW   = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);

  localparam int unsigned K_NEXT  = 0;
  localparam int unsigned K_PRE   = 1;
  localparam int unsigned K_VPLUS = 2;
  localparam int unsigned K_VDEC  = 3;
  localparam int unsigned K_PAUSE = 4;

  logic [NKEY-1:0] key_raw;

  logic [NKEY-1:0]         sync1_q,  sync1_d;
  logic [NKEY-1:0]         sync2_q,  sync2_d;
  logic [NKEY-1:0]         stable_q, stable_d;
  logic [NKEY-1:0]         press_q,  press_d;
  logic [NKEY-1:0][CW-1:0] cnt_q,    cnt_d;

  logic       fin_prev_q, fin_prev_d;
  logic       next_q,     next_d;
  logic       pre_q,      pre_d;
  logic       vplus_q,    vplus_d;
  logic       vdec_q,     vdec_d;
  logic       pause_q,    pause_d;
  logic [3:0] vol_q,      vol_d;

  logic fin_edge;
  logic next_src;
  logic pre_src;
  logic plus_only;
  logic dec_only;

  assign key_raw = {i_key_pause, i_key_vdec, i_key_vplus, i_key_pre, i_key_next};

  // The counter holds DEBOUNCE_CYC for one cycle before the stable value is taken,
  // so a level must persist past that cycle; any return to the stable value clears it.
  always_comb begin
    sync1_d  = key_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press_d  = '0;
    cnt_d    = '0;
    for (int unsigned k = 0; k < NKEY; k++) begin
      if (sync2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          stable_d[k] = sync2_q[k];
          press_d[k]  = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fin_edge  = AUTO_NEXT & i_finish_song & ~fin_prev_q;
  assign next_src  = press_q[K_NEXT] | fin_edge;
  assign pre_src   = press_q[K_PRE] & ~next_src;
  assign plus_only = press_q[K_VPLUS] & ~press_q[K_VDEC];
  assign dec_only  = press_q[K_VDEC] & ~press_q[K_VPLUS];

  always_comb begin
    fin_prev_d = i_finish_song;
    next_d     = next_src;
    pre_d      = pre_src;
    vplus_d    = plus_only;
    vdec_d     = dec_only;
    vol_d      = vol_q;
    pause_d    = pause_q;

    if (plus_only && (vol_q < VOL_MAX)) begin
      vol_d = vol_q + 4'd1;
    end else if (dec_only && (vol_q != 4'd0)) begin
      vol_d = vol_q - 4'd1;
    end

    // A track change always resumes playback, overriding a same-cycle pause toggle.
    if (next_src || pre_src) begin
      pause_d = 1'b0;
    end else if (press_q[K_PAUSE]) begin
      pause_d = ~pause_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      fin_prev_q <= 1'b0;
      next_q     <= 1'b0;
      pre_q      <= 1'b0;
      vplus_q    <= 1'b0;
      vdec_q     <= 1'b0;
      pause_q    <= 1'b0;
      vol_q      <= VOL_RESET;
    end else begin
      fin_prev_q <= fin_prev_d;
      next_q     <= next_d;
      pre_q      <= pre_d;
      vplus_q    <= vplus_d;
      vdec_q     <= vdec_d;
      pause_q    <= pause_d;
      vol_q      <= vol_d;
    end
  end

  assign o_next      = next_q;
  assign o_pre       = pre_q;
  assign o_vol_plus  = vplus_q;
  assign o_vol_dec   = vdec_q;
  assign o_pause     = pause_q;
  assign o_vol_level = vol_q;

endmodule

// File: tb/tb_mp3_key_ctrl.sv
// Directed bench for mp3_key_ctrl with DEBOUNCE_CYC=8; a second instance checks AUTO_NEXT=0.
module tb_mp3_key_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] keys = '0;
  logic       fin = 1'b0;
  logic       idle = 1'b0;

  logic       o_next, o_pre, o_vol_plus, o_vol_dec, o_pause;
  logic [3:0] o_vol_level;
  logic       o_next2, o_pre2, o_vol_plus2, o_vol_dec2, o_pause2;
  logic [3:0] o_vol_level2;

  int n_cmp = 0;
  int n_err = 0;

  int n_next = 0, n_pre = 0, n_plus = 0, n_dec = 0, n_overlap = 0, n_next2 = 0;
  logic [3:0] lvl_at_plus = '0;
  logic [3:0] lvl_at_dec = '0;

  always #5 clk = ~clk;

  mp3_key_ctrl #(.DEBOUNCE_CYC(8), .VOL_RESET(4'd8), .VOL_MAX(4'd15), .AUTO_NEXT(1'b1)) dut (
    .CLK(clk), .RST_BTN(rst_n),
    .i_key_next(keys[0]), .i_key_pre(keys[1]), .i_key_vplus(keys[2]),
    .i_key_vdec(keys[3]), .i_key_pause(keys[4]), .i_finish_song(fin),
    .o_next(o_next), .o_pre(o_pre), .o_vol_plus(o_vol_plus), .o_vol_dec(o_vol_dec),
    .o_pause(o_pause), .o_vol_level(o_vol_level)
  );

  mp3_key_ctrl #(.DEBOUNCE_CYC(8), .VOL_RESET(4'd8), .VOL_MAX(4'd15), .AUTO_NEXT(1'b0)) dut_noauto (
    .CLK(clk), .RST_BTN(rst_n),
    .i_key_next(idle), .i_key_pre(idle), .i_key_vplus(idle),
    .i_key_vdec(idle), .i_key_pause(idle), .i_finish_song(fin),
    .o_next(o_next2), .o_pre(o_pre2), .o_vol_plus(o_vol_plus2), .o_vol_dec(o_vol_dec2),
    .o_pause(o_pause2), .o_vol_level(o_vol_level2)
  );

  // Advance one clock and sample 1 time unit after the rising edge; tallies pulses.
  task automatic tick;
    @(posedge clk);
    #1;
    if (o_next) n_next++;
    if (o_pre) n_pre++;
    if (o_vol_plus) begin n_plus++; lvl_at_plus = o_vol_level; end
    if (o_vol_dec) begin n_dec++; lvl_at_dec = o_vol_level; end
    if (o_next && o_pre) n_overlap++;
    if (o_next2) n_next2++;
  endtask

  task automatic press_keys(input logic [4:0] m);
    keys = m;
    repeat (14) tick();
    keys = '0;
    repeat (14) tick();
  endtask

  task automatic test_reset;
    repeat (3) tick();
    n_cmp++;
    if ({o_next, o_pre, o_vol_plus, o_vol_dec, o_pause, o_vol_level} !== {5'b0, 4'd8}) begin
      n_err++;
      $display("FAIL reset_hold: got %b expected %b",
               {o_next, o_pre, o_vol_plus, o_vol_dec, o_pause, o_vol_level}, {5'b0, 4'd8});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if ({o_next, o_pre, o_vol_plus, o_vol_dec, o_pause, o_vol_level} !== {5'b0, 4'd8}) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: got %b expected %b", i,
                 {o_next, o_pre, o_vol_plus, o_vol_dec, o_pause, o_vol_level}, {5'b0, 4'd8});
      end
    end
  endtask

  task automatic test_next_latency;
    int base;
    keys[0] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      n_cmp++;
      if (o_next !== (i == 12)) begin
        n_err++;
        $display("FAIL next_latency cyc %0d: got %b expected %b", i, o_next, (i == 12));
      end
    end
    keys[0] = 1'b0;
    base = n_next;
    repeat (20) tick();
    n_cmp++;
    if (n_next !== base) begin
      n_err++;
      $display("FAIL next_release: got %0d pulses expected 0", n_next - base);
    end
    keys[0] = 1'b1;
    repeat (5) tick();
    keys[0] = 1'b0;
    repeat (20) tick();
    n_cmp++;
    if (n_next !== base) begin
      n_err++;
      $display("FAIL next_blip: got %0d pulses expected 0", n_next - base);
    end
  endtask

  task automatic test_volume;
    int base;
    int exp_lvl;
    base = n_plus;
    for (int i = 1; i <= 9; i++) begin
      press_keys(5'b00100);
      exp_lvl = (8 + i > 15) ? 15 : 8 + i;
      n_cmp++;
      if (o_vol_level !== 4'(exp_lvl) || lvl_at_plus !== 4'(exp_lvl)) begin
        n_err++;
        $display("FAIL vol_plus %0d: got level %0d (at pulse %0d) expected %0d",
                 i, o_vol_level, lvl_at_plus, exp_lvl);
      end
    end
    n_cmp++;
    if (n_plus - base !== 9) begin
      n_err++;
      $display("FAIL vol_plus_count: got %0d expected 9", n_plus - base);
    end
    base = n_dec;
    for (int i = 1; i <= 16; i++) begin
      press_keys(5'b01000);
      exp_lvl = (15 - i < 0) ? 0 : 15 - i;
      n_cmp++;
      if (o_vol_level !== 4'(exp_lvl) || lvl_at_dec !== 4'(exp_lvl)) begin
        n_err++;
        $display("FAIL vol_dec %0d: got level %0d (at pulse %0d) expected %0d",
                 i, o_vol_level, lvl_at_dec, exp_lvl);
      end
    end
    n_cmp++;
    if (n_dec - base !== 16) begin
      n_err++;
      $display("FAIL vol_dec_count: got %0d expected 16", n_dec - base);
    end
  endtask

  task automatic test_simultaneous;
    int bp, bd, bn, br;
    bp = n_plus; bd = n_dec;
    press_keys(5'b01100);
    n_cmp++;
    if (n_plus !== bp || n_dec !== bd || o_vol_level !== 4'd0) begin
      n_err++;
      $display("FAIL vol_both: got plus %0d dec %0d level %0d expected 0 0 0",
               n_plus - bp, n_dec - bd, o_vol_level);
    end
    bn = n_next; br = n_pre;
    press_keys(5'b00011);
    n_cmp++;
    if (n_next - bn !== 1 || n_pre !== br) begin
      n_err++;
      $display("FAIL next_pre_both: got next %0d pre %0d expected 1 0", n_next - bn, n_pre - br);
    end
    br = n_pre;
    press_keys(5'b00010);
    n_cmp++;
    if (n_pre - br !== 1) begin
      n_err++;
      $display("FAIL pre_alone: got %0d pulses expected 1", n_pre - br);
    end
  endtask

  task automatic test_pause;
    int b2;
    b2 = n_next2;
    press_keys(5'b10000);
    n_cmp++;
    if (o_pause !== 1'b1) begin n_err++; $display("FAIL pause_on: got %b expected 1", o_pause); end
    press_keys(5'b10000);
    n_cmp++;
    if (o_pause !== 1'b0) begin n_err++; $display("FAIL pause_off: got %b expected 0", o_pause); end
    press_keys(5'b10000);
    n_cmp++;
    if (o_pause !== 1'b1) begin n_err++; $display("FAIL pause_on2: got %b expected 1", o_pause); end
    fin = 1'b1;
    tick();
    n_cmp++;
    if (o_next !== 1'b1 || o_pause !== 1'b0) begin
      n_err++;
      $display("FAIL finish_next: got next %b pause %b expected 1 0", o_next, o_pause);
    end
    tick();
    n_cmp++;
    if (o_next !== 1'b0) begin n_err++; $display("FAIL finish_width: got %b expected 0", o_next); end
    repeat (5) tick();
    fin = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (n_next2 !== b2 || o_pause2 !== 1'b0 || o_vol_level2 !== 4'd8) begin
      n_err++;
      $display("FAIL noauto: got next %0d pause %b level %0d expected 0 0 8",
               n_next2 - b2, o_pause2, o_vol_level2);
    end
    press_keys(5'b10000);
    press_keys(5'b00001);
    n_cmp++;
    if (o_pause !== 1'b0) begin n_err++; $display("FAIL next_unpause: got %b expected 0", o_pause); end
    n_cmp++;
    if (n_overlap !== 0) begin n_err++; $display("FAIL overlap: got %0d expected 0", n_overlap); end
  endtask

  task automatic test_reset_mid_hold;
    press_keys(5'b10000);
    press_keys(5'b00100);
    n_cmp++;
    if (o_pause !== 1'b1 || o_vol_level !== 4'd1) begin
      n_err++;
      $display("FAIL prereset: got pause %b level %0d expected 1 1", o_pause, o_vol_level);
    end
    keys[0] = 1'b1;
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_next, o_pre, o_vol_plus, o_vol_dec, o_pause, o_vol_level} !== {5'b0, 4'd8}) begin
      n_err++;
      $display("FAIL async_reset: got %b expected %b",
               {o_next, o_pre, o_vol_plus, o_vol_dec, o_pause, o_vol_level}, {5'b0, 4'd8});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_cmp++;
      if (o_next !== (i == 12)) begin
        n_err++;
        $display("FAIL reset_relatch cyc %0d: got %b expected %b", i, o_next, (i == 12));
      end
    end
    keys[0] = 1'b0;
    repeat (14) tick();
  endtask

  initial begin
    test_reset();
    test_next_latency();
    test_volume();
    test_simultaneous();
    test_pause();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
